booth_controller: RTL and testbench

Sequencing FSM for the 8-bit radix-2 Booth multiplier datapath. It accepts a start request, loads the multiplicand and multiplier over the shared `data_in` bus, and runs N add/subtract/shift iterations. Each iteration is selected by {q0, qd}. It raises `done` when the 2N-bit product {A,Q} is valid. It sits beside the datapath inside the multiplier top level and drives every datapath control strobe.

---
 rtl/booth_pkg.sv | 20 ++
 rtl/booth_controller.sv | 96 +++++++++
 tb/tb_booth_controller.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared state encoding, ALU select constants and operand width for the Booth multiplier
package booth_pkg;

    localparam int BOOTH_N = 8;

    localparam logic ADDSUB_ADD = 1'b1;
    localparam logic ADDSUB_SUB = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_M = 3'd1,
        LOAD_Q = 3'd2,
        CHECK  = 3'd3,
        ADD    = 3'd4,
        SUB    = 3'd5,
        SHIFT  = 3'd6,
        DONE   = 3'd7
    } state_t;

endpackage

// File: rtl/booth_controller.sv
// booth_controller: Moore sequencing FSM driving the radix-2 Booth multiplier datapath strobes
module booth_controller
    import booth_pkg::*;
#(
    parameter int N = BOOTH_N
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic stop,
    input  logic q0,
    input  logic qd,
    output logic ldA,
    output logic clrA,
    output logic sftA,
    output logic ldQ,
    output logic clrQ,
    output logic sftQ,
    output logic ldM,
    output logic clrff,
    output logic addsub,
    output logic ldcount,
    output logic decount,
    output logic busy,
    output logic done
);

    localparam int SW = $clog2(N + 1) + 1;

    state_t state, nxt;
    logic [SW-1:0] shifts;

    assign clrQ = 1'b0;

    // next-state selection; CHECK must directly follow SHIFT/LOAD_Q so qd holds the pre-shift q0
    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = start ? LOAD_M : IDLE;
            LOAD_M:  nxt = LOAD_Q;
            LOAD_Q:  nxt = CHECK;
            CHECK:   nxt = stop ? DONE : ({q0, qd} == 2'b10) ? SUB : ({q0, qd} == 2'b01) ? ADD : SHIFT;
            ADD:     nxt = SHIFT;
            SUB:     nxt = SHIFT;
            SHIFT:   nxt = CHECK;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // state register; outputs are registered from the next state so they match the current state glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ldM     <= 1'b0;
            ldQ     <= 1'b0;
            clrA    <= 1'b0;
            clrff   <= 1'b0;
            ldcount <= 1'b0;
            ldA     <= 1'b0;
            addsub  <= ADDSUB_ADD;
            sftA    <= 1'b0;
            sftQ    <= 1'b0;
            decount <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= nxt;
            ldM     <= nxt == LOAD_M;
            ldQ     <= nxt == LOAD_Q;
            clrA    <= nxt == LOAD_Q;
            clrff   <= nxt == LOAD_Q;
            ldcount <= nxt == LOAD_Q;
            ldA     <= nxt == ADD || nxt == SUB;
            addsub  <= nxt == SUB ? ADDSUB_SUB : ADDSUB_ADD;
            sftA    <= nxt == SHIFT;
            sftQ    <= nxt == SHIFT;
            decount <= nxt == SHIFT;
            busy    <= nxt != IDLE;
            done    <= nxt == DONE;
        end
    end

    // tally of SHIFT visits in the current operation, used only to check the iteration count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            shifts <= '0;
        else if (ldcount)
            shifts <= '0;
        else if (decount)
            shifts <= shifts + 1'b1;
    end

    a_n_shifts: assert property (@(posedge clk) disable iff (!rst_n) done |-> shifts == SW'(N));

endmodule

// File: tb/tb_booth_controller.sv
// tb_booth_controller: drives the controller with a behavioural datapath and checks products and latency
module tb_booth_controller;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stop, q0, qd_in;
    logic ldA, clrA, sftA, ldQ, clrQ, sftQ, ldM, clrff, addsub, ldcount, decount, busy, done;

    int checks = 0;
    int failures = 0;

    // datapath state; A carries one guard bit so a subtract of -128 cannot overflow the sign
    logic [8:0] a_r = '0;
    logic [7:0] q_r = '0;
    logic [8:0] m_r = '0;
    logic       qd_r = 1'b0;
    int         cnt = 0;
    logic [7:0] mval = '0;
    logic [7:0] qval = '0;

    always #5 clk = ~clk;

    booth_controller #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .q0(q0), .qd(qd_in),
        .ldA(ldA), .clrA(clrA), .sftA(sftA), .ldQ(ldQ), .clrQ(clrQ), .sftQ(sftQ),
        .ldM(ldM), .clrff(clrff), .addsub(addsub), .ldcount(ldcount), .decount(decount),
        .busy(busy), .done(done)
    );

    assign stop  = (cnt == 0);
    assign q0    = q_r[0];
    assign qd_in = qd_r;

    // behavioural datapath reacting to the strobes
    always @(posedge clk) begin
        if (ldM) m_r <= {mval[7], mval};
        if (clrA) a_r <= '0;
        else if (ldA) a_r <= addsub ? a_r + m_r : a_r - m_r;
        else if (sftA) a_r <= {a_r[8], a_r[8:1]};
        if (ldQ) q_r <= qval;
        else if (sftQ) q_r <= {a_r[0], q_r[7:1]};
        qd_r <= clrff ? 1'b0 : q_r[0];
        if (ldcount) cnt <= N;
        else if (decount) cnt <= cnt - 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int ref_k(input logic [7:0] q);
        int k = 0;
        logic prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (q[i] != prev) k++;
            prev = q[i];
        end
        return k;
    endfunction

    function automatic logic [15:0] ref_prod(input logic [7:0] m, input logic [7:0] q);
        int p;
        p = int'($signed(m)) * int'($signed(q));
        return p[15:0];
    endfunction

    function automatic logic [12:0] outs();
        return {ldA, clrA, sftA, ldQ, clrQ, sftQ, ldM, clrff, addsub, ldcount, decount, busy, done};
    endfunction

    // runs one operation; repulse>0 pulses start again at that cycle of the operation
    task automatic run_op(input logic [7:0] m, input logic [7:0] q, input int repulse,
                          output logic [15:0] prod, output int lat, output int nadd, output int nsub,
                          output int nsft, output int ndone, output logic sub_first);
        mval = m; qval = q;
        lat = 0; nadd = 0; nsub = 0; nsft = 0; ndone = 0; sub_first = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            start = (c == repulse);
            if (ldA) begin
                if (addsub) nadd++;
                else begin
                    if (nadd == 0 && nsub == 0) sub_first = 1'b1;
                    nsub++;
                end
            end
            if (sftA) nsft++;
            if (done) begin
                ndone++;
                if (lat == 0) lat = c;
            end
            if (lat != 0 && c >= lat + 2) break;
        end
        start = 1'b0;
        prod = {a_r[7:0], q_r};
    endtask

    typedef struct {
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] prod;
        int          lat;
        int          k;
    } vec_t;

    vec_t vt[5];

    initial begin
        logic [15:0] prod;
        int lat, nadd, nsub, nsft, ndone;
        logic sub_first;
        logic [7:0] rm, rq;
        bit seen_done;

        vt[0] = '{8'h05, 8'h03, 16'h000F, 22, 2};
        vt[1] = '{8'hFC, 8'h06, 16'hFFE8, 22, 2};
        vt[2] = '{8'h80, 8'h80, 16'h4000, 21, 1};
        vt[3] = '{8'h07, 8'h55, 16'h0253, 28, 8};
        vt[4] = '{8'h07, 8'h00, 16'h0000, 20, 0};

        #12;
        chk("reset_outputs", 32'(outs()), 32'h010);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", 32'(outs()), 32'h010);

        for (int i = 0; i < 5; i++) begin
            run_op(vt[i].m, vt[i].q, 0, prod, lat, nadd, nsub, nsft, ndone, sub_first);
            chk($sformatf("vec%0d_prod", i), 32'(prod), 32'(vt[i].prod));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("vec%0d_k", i), 32'(nadd + nsub), 32'(vt[i].k));
            chk($sformatf("vec%0d_shifts", i), 32'(nsft), 32'(N));
            chk($sformatf("vec%0d_done_pulses", i), 32'(ndone), 32'd1);
            if (i == 0) begin
                chk("vec0_one_sub", 32'(nsub), 32'd1);
                chk("vec0_one_add", 32'(nadd), 32'd1);
                chk("vec0_sub_first", 32'(sub_first), 32'd1);
            end
        end

        run_op(8'h05, 8'h03, 5, prod, lat, nadd, nsub, nsft, ndone, sub_first);
        chk("repulse_prod", 32'(prod), 32'h000F);
        chk("repulse_lat", 32'(lat), 32'd22);
        chk("repulse_done_pulses", 32'(ndone), 32'd1);
        chk("repulse_idle_after", 32'(busy), 32'd0);

        mval = 8'h09; qval = 8'h11;
        seen_done = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) seen_done = 1;
        end
        chk("midreset_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", 32'(outs()), 32'h010);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done) seen_done = 1;
        end
        chk("midreset_no_done", 32'(seen_done), 32'd0);
        run_op(8'h03, 8'hFE, 0, prod, lat, nadd, nsub, nsft, ndone, sub_first);
        chk("post_reset_prod", 32'(prod), 32'hFFFA);
        chk("post_reset_lat", 32'(lat), 32'(2 * N + 4 + ref_k(8'hFE)));

        mval = 8'h0B; qval = 8'hF3;
        @(negedge clk);
        start = 1'b1;
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            if (done) lat = c;
        end
        chk("b2b_first_lat", 32'(lat), 32'(2 * N + 4 + ref_k(8'hF3)));
        @(negedge clk);
        chk("b2b_idle_after_done", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_restart_ldM", 32'(ldM), 32'd1);
        lat = 0;
        for (int c = 2; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            if (done) lat = c;
        end
        chk("b2b_second_lat", 32'(lat), 32'(2 * N + 4 + ref_k(8'hF3)));
        @(negedge clk);
        chk("b2b_second_prod", 32'({a_r[7:0], q_r}), 32'(ref_prod(8'h0B, 8'hF3)));

        for (int i = 0; i < 20; i++) begin
            rm = 8'($urandom_range(0, 255));
            rq = 8'($urandom_range(0, 255));
            run_op(rm, rq, 0, prod, lat, nadd, nsub, nsft, ndone, sub_first);
            chk($sformatf("rand%0d_prod m=%0h q=%0h", i, rm, rq), 32'(prod), 32'(ref_prod(rm, rq)));
            chk($sformatf("rand%0d_lat", i), 32'(lat), 32'(2 * N + 4 + ref_k(rq)));
            chk($sformatf("rand%0d_shifts", i), 32'(nsft), 32'(N));
            chk($sformatf("rand%0d_done_pulses", i), 32'(ndone), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
